// File: rtl/mem_access_stage.sv
// mem_access_stage: data-memory stage of the multicycle ARM core (LDR/STR).
// Latency: accept -> MEM next cycle; then WB_BASE / WB_RD when needed; a DONE pulse retires the instruction.
// Backpressure: in_ready only in IDLE; MEM holds until mem_ack or timeout; the WB states hold until wb_ready.
//
// Ports:
//   clk, nreset             clock; synchronous active-high reset
//   in_valid/in_ready       execute handshake; decoded fields are captured on the accept edge
//   cond_pass               0 squashes the instruction (no memory access, no writes)
//   base_data, offset,
//   up_down, pre_post,
//   write_back, load_store,
//   byte_word, rd, rn,
//   store_data              decoded LDR/STR operands
//   mem_*                   single data-memory transaction, req held until ack
//   wb_*                    single-port register writeback (base update first, then load)
//   done, err               retire pulse; err marks a timeout abort
//
// Optional build macro: LSU_UNALIGNED_ROTATE_EN. When it is defined, a word load from a
// non-word-aligned address is rotated right by 8*addr[1:0] (ARMv4 behaviour).
module mem_access_stage #(
  parameter int TIMEOUT_CYC = 15,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        cond_pass,
  input  logic [31:0] base_data,
  input  logic [31:0] offset,
  input  logic        up_down,
  input  logic        pre_post,
  input  logic        write_back,
  input  logic        load_store,
  input  logic        byte_word,
  input  logic [3:0]  rd,
  input  logic [3:0]  rn,
  input  logic [31:0] store_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        wb_valid,
  output logic [3:0]  wb_addr,
  output logic [31:0] wb_data,
  input  logic        wb_ready,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MEM     = 3'd1,
    S_WB_BASE = 3'd2,
    S_WB_RD   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  // Last counter value before the abort: mem_req is therefore high for exactly TIMEOUT_CYC cycles.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t state, state_nxt;

  logic             accept;
  logic [31:0]      eff_in;
  logic [31:0]      addr_in;
  logic [3:0]       be_in;
  logic [31:0]      wdata_in;

  logic [31:0]      eff_r;
  logic [31:0]      addr_r;
  logic [3:0]       be_r;
  logic [31:0]      wdata_r;
  logic             load_r;
  logic             byte_r;
  logic             base_upd_r;
  logic [3:0]       rd_r;
  logic [3:0]       rn_r;
  logic [31:0]      load_val;
  logic             err_r;
  logic [CNT_W-1:0] cnt;
  logic             timeout;
  logic [31:0]      rdata_fmt;

  assign accept = in_valid && in_ready;

  // Address arithmetic and store formatting on the raw execute inputs; results are captured on accept.
  assign eff_in  = up_down ? (base_data + offset) : (base_data - offset);
  assign addr_in = pre_post ? eff_in : base_data;

  always_comb begin
    be_in    = 4'hF;
    wdata_in = store_data;
    if (byte_word) begin
      be_in    = 4'b0001 << addr_in[1:0];
      wdata_in = {4{store_data[7:0]}};
    end
  end

  assign timeout = (TIMEOUT_CYC != 0) && (cnt == TO_LAST);

  // Load formatting uses the captured address lane.
  always_comb begin
    rdata_fmt = mem_rdata;
    if (byte_r) begin
      case (addr_r[1:0])
        2'd0:    rdata_fmt = {24'h0, mem_rdata[7:0]};
        2'd1:    rdata_fmt = {24'h0, mem_rdata[15:8]};
        2'd2:    rdata_fmt = {24'h0, mem_rdata[23:16]};
        default: rdata_fmt = {24'h0, mem_rdata[31:24]};
      endcase
    end else begin
`ifdef LSU_UNALIGNED_ROTATE_EN
      case (addr_r[1:0])
        2'd0:    rdata_fmt = mem_rdata;
        2'd1:    rdata_fmt = {mem_rdata[7:0],  mem_rdata[31:8]};
        2'd2:    rdata_fmt = {mem_rdata[15:0], mem_rdata[31:16]};
        default: rdata_fmt = {mem_rdata[23:0], mem_rdata[31:24]};
      endcase
`else
      rdata_fmt = mem_rdata;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (nreset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) state_nxt = cond_pass ? S_MEM : S_DONE;
      end
      S_MEM: begin
        // An ack arriving in the timeout cycle still completes the access.
        if (mem_ack) begin
          if (base_upd_r)  state_nxt = S_WB_BASE;
          else if (load_r) state_nxt = S_WB_RD;
          else             state_nxt = S_DONE;
        end else if (timeout) begin
          state_nxt = S_DONE;
        end
      end
      S_WB_BASE: begin
        if (wb_ready) state_nxt = load_r ? S_WB_RD : S_DONE;
      end
      S_WB_RD: begin
        if (wb_ready) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (nreset) begin
      eff_r      <= '0;
      addr_r     <= '0;
      be_r       <= '0;
      wdata_r    <= '0;
      load_r     <= 1'b0;
      byte_r     <= 1'b0;
      base_upd_r <= 1'b0;
      rd_r       <= '0;
      rn_r       <= '0;
      load_val   <= '0;
      err_r      <= 1'b0;
      cnt        <= '0;
    end else begin
      if (accept) begin
        eff_r      <= eff_in;
        addr_r     <= addr_in;
        be_r       <= be_in;
        wdata_r    <= wdata_in;
        load_r     <= load_store;
        byte_r     <= byte_word;
        base_upd_r <= write_back | ~pre_post;
        rd_r       <= rd;
        rn_r       <= rn;
        err_r      <= 1'b0;
        cnt        <= '0;
      end
      if (state == S_MEM) begin
        if (mem_ack) begin
          if (load_r) load_val <= rdata_fmt;
        end else begin
          cnt <= cnt + CNT_W'(1);
          if (timeout) err_r <= 1'b1;
        end
      end
    end
  end

  // All outputs decode from registered state and captured values only.
  always_comb begin
    in_ready  = (state == S_IDLE);
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    wb_valid  = 1'b0;
    wb_addr   = '0;
    wb_data   = '0;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      S_MEM: begin
        mem_req   = 1'b1;
        mem_we    = ~load_r;
        mem_addr  = {addr_r[31:2], 2'b00};
        mem_wdata = load_r ? 32'h0 : wdata_r;
        mem_be    = be_r;
      end
      S_WB_BASE: begin
        wb_valid = 1'b1;
        wb_addr  = rn_r;
        wb_data  = eff_r;
      end
      S_WB_RD: begin
        wb_valid = 1'b1;
        wb_addr  = rd_r;
        wb_data  = load_val;
      end
      S_DONE: begin
        done = 1'b1;
        err  = err_r;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: stores, loads, squash, timeout, backpressure, reset.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        nreset;
  logic        in_valid;
  logic        in_ready;
  logic        cond_pass;
  logic [31:0] base_data;
  logic [31:0] offset;
  logic        up_down;
  logic        pre_post;
  logic        write_back;
  logic        load_store;
  logic        byte_word;
  logic [3:0]  rd;
  logic [3:0]  rn;
  logic [31:0] store_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        wb_valid;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic        wb_ready;
  logic        done;
  logic        err;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT_CYC(15), .CNT_W(4)) dut (
    .clk(clk), .nreset(nreset),
    .in_valid(in_valid), .in_ready(in_ready), .cond_pass(cond_pass),
    .base_data(base_data), .offset(offset), .up_down(up_down), .pre_post(pre_post),
    .write_back(write_back), .load_store(load_store), .byte_word(byte_word),
    .rd(rd), .rn(rn), .store_data(store_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ready(wb_ready),
    .done(done), .err(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Presents one instruction for exactly one accept edge.
  task automatic issue(input logic cp, input logic [31:0] b, input logic [31:0] off,
                       input logic u, input logic p, input logic w, input logic l,
                       input logic by, input logic [3:0] d, input logic [3:0] n,
                       input logic [31:0] sd);
    cond_pass = cp; base_data = b; offset = off; up_down = u; pre_post = p;
    write_back = w; load_store = l; byte_word = by; rd = d; rn = n; store_data = sd;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    // Scramble the operands to show they are not sampled after accept.
    base_data = 32'hFFFF_FFFF; offset = 32'h5555_5555; store_data = 32'h0; rd = 4'hF; rn = 4'hE;
    load_store = ~l; byte_word = ~by; up_down = ~u; pre_post = ~p;
  endtask

  initial begin
    int n;
    logic [31:0] exp_rot;
    nreset = 1'b1; in_valid = 1'b0; cond_pass = 1'b0; base_data = '0; offset = '0;
    up_down = 1'b0; pre_post = 1'b0; write_back = 1'b0; load_store = 1'b0; byte_word = 1'b0;
    rd = '0; rn = '0; store_data = '0; mem_rdata = '0; mem_ack = 1'b0; wb_ready = 1'b0;
    tick(); tick();
    nreset = 1'b0;
    tick();

    // Reset state
    chk("rst_in_ready", in_ready, 1);
    chk("rst_mem_req",  mem_req, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_done",     done, 0);
    chk("rst_err",      err, 0);

    // STR word, pre, up, no W, immediate ack
    mem_ack = 1'b1;
    issue(1, 32'h100, 32'h4, 1, 1, 0, 0, 0, 4'd1, 4'd0, 32'hDEADBEEF);
    chk("str_req",   mem_req, 1);
    chk("str_we",    mem_we, 1);
    chk("str_addr",  mem_addr, 32'h104);
    chk("str_be",    mem_be, 4'hF);
    chk("str_wdata", mem_wdata, 32'hDEADBEEF);
    chk("str_busy",  in_ready, 0);
    tick();
    chk("str_done",  done, 1);
    chk("str_err",   err, 0);
    chk("str_nowb",  wb_valid, 0);
    tick();
    chk("str_idle",  in_ready, 1);
    chk("str_done0", done, 0);

    // LDRB post-index, down: base update 0x1F3 to r3 then byte lane 3 to r2
    mem_rdata = 32'h11223344; wb_ready = 1'b1;
    issue(1, 32'h203, 32'h10, 0, 0, 0, 1, 1, 4'd2, 4'd3, 32'h0);
    chk("ldrb_addr", mem_addr, 32'h200);
    chk("ldrb_we",   mem_we, 0);
    chk("ldrb_be",   mem_be, 4'b1000);
    tick();
    mem_rdata = 32'h0;
    chk("ldrb_wb1_v", wb_valid, 1);
    chk("ldrb_wb1_a", wb_addr, 4'd3);
    chk("ldrb_wb1_d", wb_data, 32'h1F3);
    chk("ldrb_req0",  mem_req, 0);
    tick();
    chk("ldrb_wb2_a", wb_addr, 4'd2);
    chk("ldrb_wb2_d", wb_data, 32'h11);
    tick();
    chk("ldrb_done",  done, 1);
    chk("ldrb_nowb",  wb_valid, 0);
    tick();

    // Squash: no memory access, done one cycle after accept
    mem_ack = 1'b0;
    issue(0, 32'h100, 32'h4, 1, 1, 1, 0, 0, 4'd1, 4'd0, 32'h1234);
    chk("sq_req",   mem_req, 0);
    chk("sq_done",  done, 1);
    chk("sq_err",   err, 0);
    chk("sq_ready", in_ready, 0);
    tick();
    chk("sq_idle",  in_ready, 1);

    // Timeout: mem_req high exactly 15 cycles, then done+err together
    issue(1, 32'h40, 32'h0, 1, 1, 0, 1, 0, 4'd4, 4'd5, 32'h0);
    n = 0;
    while (mem_req && n < 40) begin
      n++;
      tick();
    end
    chk("to_cycles", n, 15);
    chk("to_done",   done, 1);
    chk("to_err",    err, 1);
    chk("to_nowb",   wb_valid, 0);
    tick();
    chk("to_err0",   err, 0);

    // Ack in the would-be timeout cycle wins: no err
    issue(1, 32'h40, 32'h0, 1, 1, 0, 0, 0, 4'd4, 4'd5, 32'h77);
    for (int i = 0; i < 14; i++) tick();
    chk("ackwin_req", mem_req, 1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("ackwin_done", done, 1);
    chk("ackwin_err",  err, 0);
    tick();

    // Backpressure: LDR pre+W, rd==rn, wb_ready low 3 cycles in WB_BASE
    mem_ack = 1'b1; wb_ready = 1'b0; mem_rdata = 32'hCAFEF00D;
    issue(1, 32'h1000, 32'h8, 1, 1, 1, 1, 0, 4'd5, 4'd5, 32'h0);
    chk("bp_addr", mem_addr, 32'h1008);
    tick();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold_v", wb_valid, 1);
      chk("bp_hold_a", wb_addr, 4'd5);
      chk("bp_hold_d", wb_data, 32'h1008);
      tick();
    end
    chk("bp_still_d", wb_data, 32'h1008);
    wb_ready = 1'b1;
    tick();
    chk("bp_rd_a", wb_addr, 4'd5);
    chk("bp_rd_d", wb_data, 32'hCAFEF00D);
    tick();
    chk("bp_done", done, 1);
    tick();

    // Reset in the middle of MEM
    issue(1, 32'h80, 32'h0, 1, 1, 0, 1, 0, 4'd1, 4'd1, 32'h0);
    tick(); tick();
    chk("mr_pre_req", mem_req, 1);
    nreset = 1'b1;
    tick();
    chk("mr_req",   mem_req, 0);
    chk("mr_ready", in_ready, 1);
    chk("mr_done",  done, 0);
    chk("mr_wb",    wb_valid, 0);
    nreset = 1'b0;
    tick();
    chk("mr_done2", done, 0);
    chk("mr_wb2",   wb_valid, 0);

    // STRB at lane 2: replicated byte, single enable
    mem_ack = 1'b1;
    issue(1, 32'h302, 32'h0, 1, 1, 0, 0, 1, 4'd6, 4'd7, 32'h12345678);
    chk("strb_addr",  mem_addr, 32'h300);
    chk("strb_be",    mem_be, 4'b0100);
    chk("strb_wdata", mem_wdata, 32'h78787878);
    tick(); tick();

    // Word load at 0x102: rotated only when the rotate build option is on
`ifdef LSU_UNALIGNED_ROTATE_EN
    exp_rot = 32'hCCDDAABB;
`else
    exp_rot = 32'hAABBCCDD;
`endif
    mem_rdata = 32'hAABBCCDD;
    issue(1, 32'h100, 32'h2, 1, 1, 0, 1, 0, 4'd9, 4'd8, 32'h0);
    chk("ldru_addr", mem_addr, 32'h100);
    tick();
    mem_ack = 1'b0;
    chk("ldru_a", wb_addr, 4'd9);
    chk("ldru_d", wb_data, exp_rot);
    tick();
    chk("ldru_done", done, 1);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
